// File: rtl/sad_min_search_pkg.sv
// sad_min_search_pkg
//   Shared definitions for the SAD minimum search block:
//   - default widths for the reported SAD and the row/column indices
//   - FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - unsigned saturation helper used when a candidate SAD is reported
package sad_min_search_pkg;

  localparam int SUM_W_DEF = 32;
  localparam int POS_W_DEF = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Clamp an unsigned value to the largest value representable in w bits.
  function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int w);
    logic [63:0] lim;
    if (w >= 64) lim = '1;
    else         lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sad_min_search_if.sv
// sad_min_search_if
//   Beat stream and result bundle of the SAD minimum search block.
//   master: producer of beats / consumer of results (upstream side)
//   slave : the search block itself
//   Signals:
//     frame_start   - one-cycle pulse, (re)start a search frame
//     in_valid      - beat valid
//     in_ready      - block accepts a beat this cycle
//     in_lanes      - packed absolute-difference lanes, lane 0 in LSBs
//     in_row/in_col - candidate position, sampled on the first beat
//     in_frame_last - marks the final beat of the final candidate
//     min_sad       - current minimum SAD
//     min_rowcol    - {row, col} of the minimum
//     cand_count    - candidates completed in this frame
//     busy          - block is in RUN or DRAIN
//     frame_done    - one-cycle pulse, results final
interface sad_min_search_if
  import sad_min_search_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int LANE_W  = 32,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int POS_W   = POS_W_DEF
);

  logic                       frame_start;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_LANES*LANE_W-1:0]  in_lanes;
  logic [POS_W-1:0]           in_row;
  logic [POS_W-1:0]           in_col;
  logic                       in_frame_last;
  logic [SUM_W-1:0]           min_sad;
  logic [2*POS_W-1:0]         min_rowcol;
  logic [2*POS_W-1:0]         cand_count;
  logic                       busy;
  logic                       frame_done;

  modport master (
    output frame_start, in_valid, in_lanes, in_row, in_col, in_frame_last,
    input  in_ready, min_sad, min_rowcol, cand_count, busy, frame_done
  );

  modport slave (
    input  frame_start, in_valid, in_lanes, in_row, in_col, in_frame_last,
    output in_ready, min_sad, min_rowcol, cand_count, busy, frame_done
  );

endinterface

// File: rtl/sad_lane_reduce.sv
// sad_lane_reduce
//   Sums N_LANES unsigned lanes of LANE_W bits at full precision and
//   registers the result together with its valid.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset (valid only)
//     flush      - drop the beat presented this cycle and clear the valid
//     vld_p0     - input beat valid
//     lanes_p0   - packed lanes, lane 0 in LSBs
//     vld_p1     - registered sum valid
//     sum_p1     - registered lane sum (LANE_W + clog2(N_LANES) bits)
module sad_lane_reduce #(
  parameter  int N_LANES = 16,
  parameter  int LANE_W  = 32,
  localparam int RED_W   = LANE_W + $clog2(N_LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      vld_p0,
  input  logic [N_LANES*LANE_W-1:0] lanes_p0,
  output logic                      vld_p1,
  output logic [RED_W-1:0]          sum_p1
);

  logic [RED_W-1:0] sum_p0;

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < N_LANES; i++) begin
      sum_p0 = sum_p0 + RED_W'(lanes_p0[i*LANE_W +: LANE_W]);
    end
  end

  // ---- stage p0 -> p1 : registered lane sum ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0 && !flush;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) sum_p1 <= sum_p0;
  end

endmodule

// File: rtl/sad_min_search.sv
// sad_min_search
//   Pipelined sum-of-absolute-differences minimum search over a frame of
//   candidates. Each candidate spans BEATS beats of N_LANES lanes; the
//   candidate SAD is saturated to SUM_W bits and compared with the running
//   minimum. TIE_LAST=1 lets an equal SAD replace the stored minimum.
//   Pipeline: p1 lane sum, p2 candidate SAD, then min/count update.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - sad_min_search_if slave (beat stream in, results out)
module sad_min_search
  import sad_min_search_pkg::*;
#(
  parameter int N_LANES  = 16,
  parameter int LANE_W   = 32,
  parameter int SUM_W    = SUM_W_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int BEATS    = 1,
  parameter int TIE_LAST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sad_min_search_if.slave    bus
);

  localparam int RED_W = LANE_W + $clog2(N_LANES);
  localparam int ACC_W = RED_W + $clog2(BEATS);
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RC_W  = 2 * POS_W;

  state_t            st, st_nxt;
  logic              init, accept, first_beat, last_beat;
  logic [BC_W-1:0]   beat_cnt;

  logic              vld_p1, first_p1, last_p1;
  logic [RED_W-1:0]  sum_p1;
  logic [RC_W-1:0]   pos_p1;

  logic [ACC_W-1:0]  acc_p2, acc_nxt;
  logic              vld_p2;
  logic [SUM_W-1:0]  sad_p2;
  logic [RC_W-1:0]   pos_p2;

  logic [SUM_W-1:0]  min_sad;
  logic [RC_W-1:0]   min_rowcol;
  logic [RC_W-1:0]   cand_count;
  logic              upd;

  function automatic logic [SUM_W-1:0] sat_sum(input logic [ACC_W-1:0] v);
    return SUM_W'(sat_unsigned(64'(v), SUM_W));
  endfunction

  // frame_start wins over a beat presented in the same cycle
  assign init       = bus.frame_start;
  assign accept     = (st == ST_RUN) && bus.in_valid && !bus.frame_start;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == BC_W'(BEATS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  // FSM: next state
  always_comb begin
    st_nxt = st;
    if (init) begin
      st_nxt = ST_RUN;
    end else begin
      case (st)
        ST_IDLE:  st_nxt = ST_IDLE;
        ST_RUN:   if (accept && bus.in_frame_last && last_beat) st_nxt = ST_DRAIN;
        // p1 empty means the final candidate sits in p2 and commits now
        ST_DRAIN: if (!vld_p1) st_nxt = ST_DONE;
        ST_DONE:  st_nxt = ST_IDLE;
        default:  st_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs (decoded from the state register only)
  always_comb begin
    bus.in_ready   = (st == ST_RUN);
    bus.busy       = (st == ST_RUN) || (st == ST_DRAIN);
    bus.frame_done = (st == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (init)   beat_cnt <= '0;
    else if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
  end

  // ---- stage p0 -> p1 : lane reduction ----
  sad_lane_reduce #(
    .N_LANES (N_LANES),
    .LANE_W  (LANE_W)
  ) u_reduce (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (init),
    .vld_p0   (accept),
    .lanes_p0 (bus.in_lanes),
    .vld_p1   (vld_p1),
    .sum_p1   (sum_p1)
  );

  // Position is held from the first beat until the next candidate starts.
  always_ff @(posedge clk) begin
    if (accept) begin
      first_p1 <= first_beat;
      last_p1  <= last_beat;
      if (first_beat) pos_p1 <= {bus.in_row, bus.in_col};
    end
  end

  // ---- stage p1 -> p2 : candidate accumulation and saturation ----
  assign acc_nxt = first_p1 ? ACC_W'(sum_p1) : acc_p2 + ACC_W'(sum_p1);

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      acc_p2 <= acc_nxt;
      if (last_p1) begin
        sad_p2 <= sat_sum(acc_nxt);
        pos_p2 <= pos_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p2 <= 1'b0;
    else if (init) vld_p2 <= 1'b0;
    else           vld_p2 <= vld_p1 && last_p1;
  end

  // ---- stage p2 -> result : minimum compare and update ----
  assign upd = (sad_p2 < min_sad) || ((TIE_LAST != 0) && (sad_p2 == min_sad));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad    <= '1;
      min_rowcol <= '0;
      cand_count <= '0;
    end else if (init) begin
      min_sad    <= '1;
      min_rowcol <= '0;
      cand_count <= '0;
    end else if (vld_p2) begin
      cand_count <= cand_count + RC_W'(1);
      if (upd) begin
        min_sad    <= sad_p2;
        min_rowcol <= pos_p2;
      end
    end
  end

  assign bus.min_sad    = min_sad;
  assign bus.min_rowcol = min_rowcol;
  assign bus.cand_count = cand_count;

endmodule

// File: tb/tb_sad_min_search.sv
// tb_sad_min_search
//   Directed bench for sad_min_search. Four instances share one stimulus:
//   a = defaults (TIE_LAST=1), b = TIE_LAST=0, c = BEATS=4,
//   d = LANE_W=8/SUM_W=8 for saturation. Each scenario checks the
//   instance it targets.
module tb_sad_min_search;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fs = 1'b0, vld = 1'b0, flast = 1'b0;
  logic [5:0]   row = '0, col = '0;
  logic [511:0] lanes = '0;
  logic [511:0] lv;
  logic [127:0] lanes_d;
  int           nvec = 0;
  int           nerr = 0;

  always #5 clk = ~clk;

  always_comb begin
    lanes_d = '0;
    for (int i = 0; i < 16; i++) lanes_d[i*8 +: 8] = lanes[i*32 +: 8];
  end

  sad_min_search_if                               if_a ();
  sad_min_search_if                               if_b ();
  sad_min_search_if                               if_c ();
  sad_min_search_if #(.LANE_W(8), .SUM_W(8))      if_d ();

  assign if_a.frame_start = fs;  assign if_a.in_valid = vld;  assign if_a.in_lanes = lanes;
  assign if_a.in_row = row;      assign if_a.in_col = col;    assign if_a.in_frame_last = flast;
  assign if_b.frame_start = fs;  assign if_b.in_valid = vld;  assign if_b.in_lanes = lanes;
  assign if_b.in_row = row;      assign if_b.in_col = col;    assign if_b.in_frame_last = flast;
  assign if_c.frame_start = fs;  assign if_c.in_valid = vld;  assign if_c.in_lanes = lanes;
  assign if_c.in_row = row;      assign if_c.in_col = col;    assign if_c.in_frame_last = flast;
  assign if_d.frame_start = fs;  assign if_d.in_valid = vld;  assign if_d.in_lanes = lanes_d;
  assign if_d.in_row = row;      assign if_d.in_col = col;    assign if_d.in_frame_last = flast;

  sad_min_search                                  dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  sad_min_search #(.TIE_LAST(0))                  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  sad_min_search #(.BEATS(4))                     dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  sad_min_search #(.LANE_W(8), .SUM_W(8))         dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  typedef struct packed {
    logic        start;
    logic [5:0]  row;
    logic [5:0]  col;
    logic [31:0] val;
    logic        last;
    logic [31:0] sad;
    logic [11:0] rc;
    logic [11:0] cnt;
    logic        done;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic beat(input logic [5:0] r, input logic [5:0] c,
                      input logic [511:0] l, input logic last);
    vld = 1'b1; row = r; col = c; lanes = l; flast = last;
    @(negedge clk);
    vld = 1'b0; flast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    //            start row   col   val    last  sad     rc       cnt    done
    tbl[0] = '{1'b1, 6'd1, 6'd2, 32'd3, 1'b0, 32'd48, 12'd66,  12'd1, 1'b0};
    tbl[1] = '{1'b0, 6'd4, 6'd5, 32'd1, 1'b1, 32'd16, 12'd261, 12'd2, 1'b1};
    tbl[2] = '{1'b1, 6'd7, 6'd7, 32'd2, 1'b0, 32'd32, 12'd455, 12'd1, 1'b0};
    tbl[3] = '{1'b0, 6'd3, 6'd9, 32'd5, 1'b0, 32'd32, 12'd455, 12'd2, 1'b0};
    tbl[4] = '{1'b0, 6'd2, 6'd8, 32'd2, 1'b0, 32'd32, 12'd136, 12'd3, 1'b0};
    tbl[5] = '{1'b0, 6'd6, 6'd1, 32'd0, 1'b1, 32'd0,  12'd385, 12'd4, 1'b1};

    // reset values
    idle(2);
    check("rst.in_ready",   64'(if_a.in_ready),   64'd0);
    check("rst.busy",       64'(if_a.busy),       64'd0);
    check("rst.frame_done", 64'(if_a.frame_done), 64'd0);
    check("rst.min_sad",    64'(if_a.min_sad),    64'hFFFF_FFFF);
    check("rst.min_rowcol", 64'(if_a.min_rowcol), 64'd0);
    check("rst.cand_count", 64'(if_a.cand_count), 64'd0);
    check("rst.min_sad_d",  64'(if_d.min_sad),    64'd255);
    rst_n = 1'b1;
    idle(1);

    // in_valid while IDLE is ignored
    vld = 1'b1; row = 6'd1; col = 6'd1; lanes = fill(32'd1);
    idle(3);
    vld = 1'b0;
    check("idle.busy",       64'(if_a.busy),       64'd0);
    check("idle.cand_count", 64'(if_a.cand_count), 64'd0);
    check("idle.min_sad",    64'(if_a.min_sad),    64'hFFFF_FFFF);

    // table-driven single-beat candidates on the default instance
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].start) pulse_fs();
      beat(tbl[i].row, tbl[i].col, fill(tbl[i].val), tbl[i].last);
      idle(2);
      check($sformatf("tbl%0d.min_sad", i),    64'(if_a.min_sad),    64'(tbl[i].sad));
      check($sformatf("tbl%0d.min_rowcol", i), 64'(if_a.min_rowcol), 64'(tbl[i].rc));
      check($sformatf("tbl%0d.cand_count", i), 64'(if_a.cand_count), 64'(tbl[i].cnt));
      check($sformatf("tbl%0d.frame_done", i), 64'(if_a.frame_done), 64'(tbl[i].done));
    end
    idle(1);
    check("post.frame_done", 64'(if_a.frame_done), 64'd0);
    check("post.busy",       64'(if_a.busy),       64'd0);

    // equal SADs back-to-back: TIE_LAST=1 keeps the later, 0 the earlier
    lv = '0; lv[31:0] = 32'd10;
    pulse_fs();
    beat(6'd0, 6'd1, lv, 1'b0);
    beat(6'd0, 6'd2, lv, 1'b1);
    idle(2);
    check("tie1.frame_done", 64'(if_a.frame_done), 64'd1);
    check("tie1.min_sad",    64'(if_a.min_sad),    64'd10);
    check("tie1.min_rowcol", 64'(if_a.min_rowcol), 64'd2);
    check("tie0.frame_done", 64'(if_b.frame_done), 64'd1);
    check("tie0.min_sad",    64'(if_b.min_sad),    64'd10);
    check("tie0.min_rowcol", 64'(if_b.min_rowcol), 64'd1);
    check("tie0.cand_count", 64'(if_b.cand_count), 64'd2);

    // four beats per candidate; frame_last on a non-final beat is ignored
    idle(1);
    pulse_fs();
    beat(6'd1, 6'd1, fill(32'd1), 1'b0);
    beat(6'd1, 6'd1, fill(32'd1), 1'b1);
    check("b4.ready_after_early_last", 64'(if_c.in_ready), 64'd1);
    beat(6'd1, 6'd1, fill(32'd1), 1'b0);
    beat(6'd1, 6'd1, fill(32'd1), 1'b0);
    beat(6'd2, 6'd3, fill(32'd1), 1'b0);
    beat(6'd9, 6'd9, fill(32'd1), 1'b0);
    beat(6'd9, 6'd9, fill(32'd1), 1'b0);
    beat(6'd9, 6'd9, fill(32'd1), 1'b1);
    check("b4.drain_ready", 64'(if_c.in_ready), 64'd0);
    idle(2);
    check("b4.frame_done", 64'(if_c.frame_done), 64'd1);
    check("b4.min_sad",    64'(if_c.min_sad),    64'd64);
    check("b4.min_rowcol", 64'(if_c.min_rowcol), 64'd131);
    check("b4.cand_count", 64'(if_c.cand_count), 64'd2);

    // saturation with 8-bit SAD
    idle(1);
    pulse_fs();
    beat(6'd3, 6'd3, fill(32'd255), 1'b0);
    idle(2);
    check("sat.min_sad",    64'(if_d.min_sad),    64'd255);
    check("sat.min_rowcol", 64'(if_d.min_rowcol), 64'd195);
    check("sat.cand_count", 64'(if_d.cand_count), 64'd1);
    lv = '0; lv[31:0] = 32'd254;
    beat(6'd5, 6'd6, lv, 1'b1);
    idle(2);
    check("sat2.min_sad",    64'(if_d.min_sad),    64'd254);
    check("sat2.min_rowcol", 64'(if_d.min_rowcol), 64'd326);
    check("sat2.frame_done", 64'(if_d.frame_done), 64'd1);

    // frame_start mid-RUN drops the in-flight candidate and a coincident beat
    idle(1);
    pulse_fs();
    beat(6'd1, 6'd1, fill(32'd2), 1'b0);
    idle(2);
    check("abort.pre_count", 64'(if_a.cand_count), 64'd1);
    check("abort.pre_sad",   64'(if_a.min_sad),    64'd32);
    idle(1);
    beat(6'd2, 6'd2, fill(32'd1), 1'b0);
    fs = 1'b1; vld = 1'b1; row = 6'd3; col = 6'd3; lanes = '0;
    @(negedge clk);
    fs = 1'b0; vld = 1'b0;
    check("abort.count",  64'(if_a.cand_count), 64'd0);
    check("abort.sad",    64'(if_a.min_sad),    64'hFFFF_FFFF);
    check("abort.rowcol", 64'(if_a.min_rowcol), 64'd0);
    check("abort.busy",   64'(if_a.busy),       64'd1);
    idle(2);
    check("abort.flushed_count", 64'(if_a.cand_count), 64'd0);
    check("abort.flushed_sad",   64'(if_a.min_sad),    64'hFFFF_FFFF);
    beat(6'd4, 6'd4, fill(32'd1), 1'b1);
    idle(2);
    check("abort.post_sad",    64'(if_a.min_sad),    64'd16);
    check("abort.post_rowcol", 64'(if_a.min_rowcol), 64'd260);
    check("abort.post_count",  64'(if_a.cand_count), 64'd1);
    check("abort.post_done",   64'(if_a.frame_done), 64'd1);

    // reset asserted during DRAIN
    idle(1);
    pulse_fs();
    beat(6'd1, 6'd2, fill(32'd3), 1'b1);
    check("drain.busy",  64'(if_a.busy),     64'd1);
    check("drain.ready", 64'(if_a.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rstdrain.busy",       64'(if_a.busy),       64'd0);
    check("rstdrain.frame_done", 64'(if_a.frame_done), 64'd0);
    check("rstdrain.min_sad",    64'(if_a.min_sad),    64'hFFFF_FFFF);
    check("rstdrain.min_rowcol", 64'(if_a.min_rowcol), 64'd0);
    check("rstdrain.cand_count", 64'(if_a.cand_count), 64'd0);
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstdrain.no_done%0d", i), 64'(if_a.frame_done), 64'd0);
    end
    check("rstdrain.final_count", 64'(if_a.cand_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
# sad_min_search

Parametrised, pipelined sum-of-absolute-differences minimum search. It accepts a stream of per-candidate absolute-difference lanes, reduces each candidate to one saturated SAD over a configurable number of beats, and tracks the minimum SAD and its packed row/column across a search frame. It sits between the per-pixel absolute-difference units and the motion-vector writeback, replacing the single-shot combinational SAD/compare stage with a handshaked, frame-oriented block.

## Interface
- N_LANES, 16, absolute-difference lanes per beat
- LANE_W, 32, width of each lane
- SUM_W, 32, width of reported SAD (saturating)
- POS_W, 6, row and column index width each
- BEATS, 1, beats per candidate (≥1)
- TIE_LAST, 1, 1: equal SAD replaces stored minimum; 0: first minimum kept
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Frame_Start  in  1  one-cycle pulse; initialise and begin a search frame
- In_Valid  in  1  beat valid
- In_Ready  out  1  block accepts a beat this cycle
- In_Lanes  in  N_LANES*LANE_W  packed lanes, lane 0 in LSBs
- In_Row  in  POS_W  candidate row, sampled on candidate's first beat
- In_Col  in  POS_W  candidate column, sampled on first beat
- In_Frame_Last  in  1  qualifies the final beat of the final candidate
- Min_Sad  out  SUM_W  current minimum SAD
- Min_RowCol  out  2*POS_W  {row, col} of minimum
- Cand_Count  out  2*POS_W  candidates completed this frame
- Busy  out  1  state is RUN or DRAIN
- Frame_Done  out  1  one-cycle pulse, results final

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE: Frame_Start → RUN; Min_Sad ← all ones, Min_RowCol ← 0, Cand_Count ← 0, beat counter ← 0, pipeline valids cleared.
- RUN: In_Ready = 1; beat accepted when In_Valid && In_Ready. Accepted beat with In_Frame_Last → DRAIN. In_Frame_Last is honoured only on a candidate's last beat (beat counter = BEATS-1); otherwise ignored.
- DRAIN: In_Ready = 0; remains until pipeline empty (exactly 2 cycles), then → DONE with Frame_Done high for that one cycle. DONE holds outputs; falls to IDLE after one cycle.
- Frame_Start in RUN or DRAIN aborts: in-flight beats discarded, re-initialise, stay/enter RUN. Frame_Start has priority over a simultaneous accepted beat (beat dropped).
- Stage 1 (lane reduce): sum all N_LANES lanes at full precision (LANE_W+clog2(N_LANES)), register.
- Stage 2 (accumulate): add to candidate accumulator; cleared at first beat. At last beat produce candidate SAD, saturated to 2^SUM_W−1.
- Stage 3 (compare): SAD < Min_Sad, or (TIE_LAST && SAD == Min_Sad) → update Min_Sad, Min_RowCol. Cand_Count increments per completed candidate, wraps at 2^(2*POS_W).
- Since Min_Sad initialises to all ones, a saturated candidate with TIE_LAST=1 still updates; with TIE_LAST=0 a frame of all-saturated candidates reports RowCol 0.
- In_Valid outside RUN ignored; no state change.

## Timing
- Reset values: In_Ready 0, Busy 0, Frame_Done 0, Min_Sad all ones, Min_RowCol 0, Cand_Count 0.
- Throughput: one beat per cycle in RUN, no bubbles.
- Last beat of candidate accepted at edge k: lane sum registered k, SAD complete k+1, Min_Sad/Min_RowCol/Cand_Count updated at k+2.
- Frame-last beat at edge k: DRAIN cycles k..k+2, Frame_Done high in cycle after edge k+2 update edge; Frame_Done coincides with final Min values.
- Outputs registered; no combinational path from In_* to outputs except none (In_Ready from state only).
- Rst_n low mid-frame: all state cleared immediately; frame lost.

## Structure
- Shared package: state encoding localparams (IDLE, RUN, DRAIN, DONE), saturation helper function, SUM_W/POS_W defaults.
- One sub-module: sad_lane_reduce (parametrised N_LANES, LANE_W adder tree, registered output with valid).
- Top module holds FSM, beat counter, accumulator, compare/update.

## Test plan
- N_LANES=16, BEATS=1: Frame_Start, candidates (1,2) lanes all 3 (SAD 48), (4,5) lanes all 1 (SAD 16) frame-last → Frame_Done, Min_Sad=16, Min_RowCol={4,5}, Cand_Count=2.
- TIE_LAST=1 vs 0: two candidates (0,1),(0,2) both SAD 10 → RowCol {0,2} vs {0,1}.
- BEATS=4: four beats of lanes all 1 per candidate → SAD 64; In_Frame_Last on beat 2 ignored, frame ends on beat 4 only.
- Saturation: SUM_W=8, lanes 255 → SAD 255; following candidate SAD 254 updates minimum.
- In_Valid held with gaps and Frame_Start pulse mid-RUN → in-flight candidate discarded, Cand_Count restarts at 0, later results correct.
- Rst_n deasserted low during DRAIN → outputs at reset values, no Frame_Done.
